// File: rtl/rv_exec_pkg.sv
// Shared definitions for the multi-cycle execute controller: unit codes,
// controller states and small helpers for unit-code decoding.
package rv_exec_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NUM_UNITS = 5;

  typedef enum logic [2:0] {
    UNIT_MDU_MUL    = 3'd0,
    UNIT_MDU_DIV    = 3'd1,
    UNIT_FPU_ADDSUB = 3'd2,
    UNIT_FPU_MUL    = 3'd3,
    UNIT_FPU_DIV    = 3'd4
  } unit_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef logic [NUM_UNITS-1:0] start_t;

  function automatic logic unit_legal(input logic [2:0] code);
    return code < 3'(NUM_UNITS);
  endfunction

  // Codes past the last unit shift out entirely, giving an all-zero vector.
  function automatic start_t unit_onehot(input logic [2:0] code);
    return start_t'(1) << code;
  endfunction

endpackage

// File: rtl/multicycle_exec_ctrl_if.sv
// Pipeline/unit-side bundle of the multi-cycle execute controller.
interface multicycle_exec_ctrl_if
  import rv_exec_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);

  logic                 req_valid;
  logic [2:0]           req_unit;
  logic [2:0]           req_op;
  logic [XLEN-1:0]      req_a;
  logic [XLEN-1:0]      req_b;
  logic [4:0]           req_rd;
  logic                 req_fp;
  logic                 flush;
  logic                 stall;
  logic [NUM_UNITS-1:0] unit_start;
  logic [2:0]           unit_sel;
  logic [2:0]           unit_op;
  logic [XLEN-1:0]      unit_a;
  logic [XLEN-1:0]      unit_b;
  logic                 done_in;
  logic [XLEN-1:0]      result_in;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic                 wb_fp;
  logic [XLEN-1:0]      wb_data;
  logic                 err;

  modport slave (
    input  req_valid, req_unit, req_op, req_a, req_b, req_rd, req_fp, flush,
           done_in, result_in,
    output stall, unit_start, unit_sel, unit_op, unit_a, unit_b,
           wb_valid, wb_rd, wb_fp, wb_data, err
  );

  modport master (
    output req_valid, req_unit, req_op, req_a, req_b, req_rd, req_fp, flush,
           done_in, result_in,
    input  stall, unit_start, unit_sel, unit_op, unit_a, unit_b,
           wb_valid, wb_rd, wb_fp, wb_data, err
  );

endinterface

// File: rtl/mc_timeout_cnt.sv
// 8-bit clear/enable cycle counter flagging when the current enabled cycle
// brings the elapsed count to TIMEOUT.
module mc_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compared against the incremented value so the flag fires on the
  // TIMEOUT-th counted cycle itself rather than one cycle later.
  assign hit_o = en_i && !clr_i && (cnt_d == 8'(TIMEOUT));

endmodule

// File: rtl/multicycle_exec_ctrl.sv
// Execute-stage controller sequencing one multi-cycle MDU/FPU operation at a
// time: latch, start pulse, wait for done, writeback, with flush and timeout.
module multicycle_exec_ctrl
  import rv_exec_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_exec_ctrl_if.slave  bus
);

  state_e          state_q, state_d;
  logic [2:0]      unit_q, unit_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [4:0]      rd_q, rd_d;
  logic            fp_q, fp_d;
  logic [XLEN-1:0] data_q, data_d;

  logic stall, err, start_en, wb_valid;
  logic cnt_clr, cnt_en, cnt_hit;

  mc_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .hit_o (cnt_hit)
  );

  always_comb begin
    state_d  = state_q;
    unit_d   = unit_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    fp_d     = fp_q;
    data_d   = data_q;
    stall    = 1'b0;
    err      = 1'b0;
    start_en = 1'b0;
    wb_valid = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && !unit_legal(bus.req_unit)) begin
          err = 1'b1;
        end else if (bus.req_valid && !bus.flush) begin
          stall   = 1'b1;
          unit_d  = bus.req_unit;
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          rd_d    = bus.req_rd;
          fp_d    = bus.req_fp;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        stall   = 1'b1;
        cnt_clr = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          start_en = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        // A result arriving together with a flush is dropped outright, since
        // the unit is already idle and draining would only wait for a timeout.
        if (bus.done_in) begin
          if (bus.flush) begin
            state_d = ST_IDLE;
          end else begin
            data_d  = bus.result_in;
            state_d = ST_WB;
          end
        end else if (cnt_hit) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_WB: begin
        wb_valid = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_DRAIN: begin
        // Counter keeps running from WAIT, bounding the whole abandoned op.
        stall  = bus.req_valid;
        cnt_en = 1'b1;
        if (bus.done_in) begin
          state_d = ST_IDLE;
        end else if (cnt_hit) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      unit_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      fp_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      fp_q    <= fp_d;
      data_q  <= data_d;
    end
  end

  // Request-driven outputs are masked while reset is held.
  assign bus.stall      = stall && rst_n;
  assign bus.err        = err && rst_n;
  assign bus.unit_start = start_en ? unit_onehot(unit_q) : '0;
  assign bus.unit_sel   = unit_q;
  assign bus.unit_op    = op_q;
  assign bus.unit_a     = a_q;
  assign bus.unit_b     = b_q;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_rd      = rd_q;
  assign bus.wb_fp      = fp_q;
  assign bus.wb_data    = data_q;

endmodule

// File: tb/tb_multicycle_exec_ctrl.sv
// Self-checking bench for multicycle_exec_ctrl: idle decode table, directed
// multi-cycle sequences and randomized ops against a timeline model.
module tb_multicycle_exec_ctrl;

  localparam int TMO = 40;

  logic clk;
  logic rst_n;

  multicycle_exec_ctrl_if #(.XLEN(32)) bus ();
  multicycle_exec_ctrl_if #(.XLEN(32)) bus8 ();

  multicycle_exec_ctrl #(.XLEN(32), .TIMEOUT(TMO)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multicycle_exec_ctrl #(.XLEN(32), .TIMEOUT(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rv;
    logic [2:0] unit;
    logic       fl;
    logic       exp_stall;
    logic       exp_err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle_inputs();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.done_in   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_idle_inputs();
      bus.done_in   = 1'($urandom_range(0, 1));
      bus.result_in = $urandom;
      #1;
      chk("idle_stall", bus.stall, 0);
      chk("idle_start", bus.unit_start, 0);
      chk("idle_err", bus.err, 0);
      chk("idle_wb", bus.wb_valid, 0);
    end
  endtask

  // Timeline model of one op accepted at t=0: start at t=1, WAIT from t=2,
  // done at WAIT cycle d (t=1+d), writeback the cycle after. d<=0 means the
  // unit never answers; fc is the cycle carrying flush (-1 for none).
  task automatic run_op(input logic [2:0] unit, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic fp,
                        input int d, input int fc, input logic [31:0] res);
    bit legal, tmo, wbk;
    int end_t;
    legal = (unit < 3'd5);
    tmo   = legal && (fc < 0) && (d <= 0 || d > TMO);
    wbk   = legal && (fc < 0) && !tmo;
    if (!legal)       end_t = 0;
    else if (fc == 1) end_t = 1;
    else if (fc >= 2) end_t = 1 + d;
    else if (tmo)     end_t = 1 + TMO;
    else              end_t = 2 + d;
    for (int t = 0; t <= end_t; t++) begin
      logic       rv, e_stall, e_err, e_wb;
      logic [4:0] e_start;
      @(negedge clk);
      rv = (fc < 0) || (t <= fc);
      bus.req_valid = rv;
      bus.req_unit  = unit;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_rd    = rd;
      bus.req_fp    = fp;
      bus.flush     = (t == fc);
      if (legal && d > 0 && t == 1 + d) begin
        bus.done_in   = 1'b1;
        bus.result_in = res;
      end else begin
        bus.done_in   = (t <= 1 || (wbk && t == end_t)) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.result_in = $urandom;
      end
      e_stall = legal && !(wbk && t == end_t) && !(fc >= 2 && t > fc);
      e_start = (legal && t == 1 && fc != 1) ? (5'(1) << unit) : 5'd0;
      e_err   = (!legal && t == 0) || (tmo && t == end_t);
      e_wb    = wbk && (t == end_t);
      #1;
      chk("op_stall", bus.stall, e_stall);
      chk("op_start", bus.unit_start, e_start);
      chk("op_err", bus.err, e_err);
      chk("op_wb_valid", bus.wb_valid, e_wb);
      if (e_wb) begin
        chk("op_wb_rd", bus.wb_rd, rd);
        chk("op_wb_fp", bus.wb_fp, fp);
        chk("op_wb_data", bus.wb_data, res);
      end
      if (legal && t >= 1) begin
        chk("op_unit_sel", bus.unit_sel, unit);
        chk("op_unit_op", bus.unit_op, op);
        chk("op_unit_a", bus.unit_a, a);
        chk("op_unit_b", bus.unit_b, b);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, bus.stall, 0);
    chk({tag, "_start"}, bus.unit_start, 0);
    chk({tag, "_sel"}, bus.unit_sel, 0);
    chk({tag, "_op"}, bus.unit_op, 0);
    chk({tag, "_a"}, bus.unit_a, 0);
    chk({tag, "_b"}, bus.unit_b, 0);
    chk({tag, "_wb_valid"}, bus.wb_valid, 0);
    chk({tag, "_wb_rd"}, bus.wb_rd, 0);
    chk({tag, "_wb_fp"}, bus.wb_fp, 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 3'd4, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 3'd5, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 3'd6, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 3'd7, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 3'd1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive_idle_inputs();
    bus.req_unit = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_rd = '0; bus.req_fp = 1'b0; bus.result_in = '0;
    bus8.req_valid = 1'b0; bus8.req_unit = '0; bus8.req_op = '0;
    bus8.req_a = '0; bus8.req_b = '0; bus8.req_rd = '0; bus8.req_fp = 1'b0;
    bus8.flush = 1'b0; bus8.done_in = 1'b0; bus8.result_in = '0;

    // Reset holds everything at zero even with a legal request present.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_unit  = 3'd0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle_inputs();

    // Idle decode table: inputs withdrawn before the edge so nothing is accepted.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req_valid = tbl[i].rv;
      bus.req_unit  = tbl[i].unit;
      bus.flush     = tbl[i].fl;
      #1;
      chk("tbl_stall", bus.stall, tbl[i].exp_stall);
      chk("tbl_err", bus.err, tbl[i].exp_err);
      chk("tbl_start", bus.unit_start, 0);
      chk("tbl_wb", bus.wb_valid, 0);
      drive_idle_inputs();
    end

    // Directed ops, back to back where no gap is inserted.
    run_op(3'd0, 3'd0, 32'd7, 32'd6, 5'd9, 1'b0, 3, -1, 32'd42);
    run_op(3'd4, 3'd1, 32'h4040_0000, 32'h3f80_0000, 5'd3, 1'b1, 30, -1, 32'h4040_0000);
    run_op(3'd6, 3'd0, 32'd1, 32'd2, 5'd1, 1'b0, 0, -1, 32'd0);
    idle_cycles(2);
    run_op(3'd1, 3'd5, 32'd100, 32'd7, 5'd11, 1'b0, 1, -1, 32'd14);
    run_op(3'd2, 3'd1, 32'h1234, 32'h5678, 5'd20, 1'b1, TMO, -1, 32'hCAFE_F00D);
    run_op(3'd3, 3'd0, 32'd5, 32'd5, 5'd21, 1'b1, TMO + 1, -1, 32'd0);
    run_op(3'd0, 3'd0, 32'd9, 32'd9, 5'd22, 1'b0, 4, 1, 32'd81);
    run_op(3'd1, 3'd4, 32'd9, 32'd3, 5'd23, 1'b0, 5, 6, 32'd3);
    idle_cycles(1);

    // Flush two cycles into WAIT; new request stalls in DRAIN until the
    // abandoned op's done arrives, then issues normally.
    for (int c = 0; c <= 18; c++) begin
      logic       e_stall;
      logic [4:0] e_start;
      @(negedge clk);
      bus.req_valid = (c <= 3) || (c >= 6);
      bus.req_unit  = (c <= 3) ? 3'd1 : 3'd0;
      bus.req_op    = 3'd0;
      bus.req_a     = (c <= 3) ? 32'd50 : 32'd3;
      bus.req_b     = (c <= 3) ? 32'd2 : 32'd5;
      bus.req_rd    = (c <= 3) ? 5'd4 : 5'd7;
      bus.req_fp    = 1'b0;
      bus.flush     = (c == 3);
      bus.done_in   = (c == 13) || (c == 17);
      bus.result_in = (c == 17) ? 32'd15 : 32'hDEAD_BEEF;
      e_stall = !(c == 4 || c == 5 || c == 18);
      e_start = (c == 1) ? 5'b00010 : (c == 15) ? 5'b00001 : 5'b00000;
      #1;
      chk("drain_stall", bus.stall, e_stall);
      chk("drain_start", bus.unit_start, e_start);
      chk("drain_err", bus.err, 0);
      chk("drain_wb_valid", bus.wb_valid, (c == 18));
      if (c == 18) begin
        chk("drain_wb_rd", bus.wb_rd, 5'd7);
        chk("drain_wb_data", bus.wb_data, 32'd15);
      end
    end
    idle_cycles(1);

    // Randomized ops with random gaps (zero gap exercises back-to-back).
    for (int n = 0; n < 60; n++) begin
      int kind, d, fc;
      logic [2:0] unit;
      kind = $urandom_range(0, 11);
      unit = 3'($urandom_range(0, 4));
      fc = -1;
      d  = $urandom_range(1, 12);
      case (kind)
        0: unit = 3'($urandom_range(5, 7));
        1: fc = 1;
        2, 3: begin d = $urandom_range(2, 15); fc = $urandom_range(2, 1 + d); end
        4: d = (n % 3 == 0) ? 0 : $urandom_range(13, TMO);
        default: ;
      endcase
      run_op(unit, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
             d, fc, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    // TIMEOUT=8 instance: unit never answers, error on the 8th WAIT cycle.
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      bus8.req_valid = (c <= 9);
      bus8.req_unit  = 3'd3;
      bus8.done_in   = 1'b0;
      #1;
      chk("tmo8_stall", bus8.stall, (c <= 9));
      chk("tmo8_err", bus8.err, (c == 9));
      chk("tmo8_start", bus8.unit_start, (c == 1) ? 5'b01000 : 5'b00000);
      chk("tmo8_wb", bus8.wb_valid, 0);
    end

    // Reset during WAIT, then a late done after release.
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      bus.req_valid = (c <= 4);
      bus.req_unit  = 3'd2;
      bus.req_op    = 3'd1;
      bus.req_a     = 32'hAAAA_5555;
      bus.req_b     = 32'h0F0F_F0F0;
      bus.req_rd    = 5'd17;
      bus.req_fp    = 1'b1;
      bus.flush     = 1'b0;
      bus.done_in   = (c == 6);
      bus.result_in = 32'h7777_7777;
      if (c == 4) rst_n = 1'b0;
      if (c == 5) rst_n = 1'b1;
      #1;
      if (c == 4) begin
        chk_all_zero("rst_mid");
      end else if (c >= 5) begin
        chk("post_rst_stall", bus.stall, 0);
        chk("post_rst_start", bus.unit_start, 0);
        chk("post_rst_wb", bus.wb_valid, 0);
        chk("post_rst_err", bus.err, 0);
      end else begin
        chk("pre_rst_stall", bus.stall, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
